// File: rtl/uop_fifo_nw_if.sv
// Bundle of the micro-op queue signals: producer-side writes, consumer stall,
// and the head/status outputs of the queue.
interface uop_fifo_nw_if #(
    parameter int UOP_W = 39,
    parameter int DEPTH = 16,
    parameter int NWR   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   flush;
    logic [NWR*UOP_W-1:0]   IN_uop;
    logic [NWR-1:0]         WR_EN;
    logic                   pipe_stall;
    logic [UOP_W-1:0]       OUT_uop;
    logic                   OUT_valid;
    logic                   Q_full;
    logic [CW-1:0]          count;
    logic                   ovf;

    modport master (
        output flush, IN_uop, WR_EN, pipe_stall,
        input  OUT_uop, OUT_valid, Q_full, count, ovf
    );

    modport slave (
        input  flush, IN_uop, WR_EN, pipe_stall,
        output OUT_uop, OUT_valid, Q_full, count, ovf
    );
endinterface

// File: rtl/uop_fifo_nw.sv
// Multi-write, single-read micro-op queue: up to NWR compacted writes per cycle
// into a circular buffer, one dequeue per cycle, sticky overflow on rejected groups.
module uop_fifo_nw #(
    parameter int UOP_W = 39,
    parameter int DEPTH = 16,
    parameter int NWR   = 4
) (
    input logic          CLK,
    input logic          RST,
    uop_fifo_nw_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 * NWR || (DEPTH & (DEPTH - 1)) != 0 || NWR < 1 || NWR > 8) begin : g_param_err
        $error("uop_fifo_nw: DEPTH must be a power of two >= 2*NWR, NWR in 1..8");
    end

    logic [UOP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic [CW-1:0]    cnt;
    logic             ovf_q;

    logic [AW-1:0]    waddr [NWR];
    logic [CW-1:0]    n_wr;
    logic [CW-1:0]    free_cnt;
    logic [CW-1:0]    cnt_next;
    logic             accept;
    logic             deq;

    // Each enabled port lands at wp plus the number of enabled ports below it,
    // which packs gapped enables into consecutive slots.
    always_comb begin
        n_wr = '0;
        for (int k = 0; k < NWR; k++) begin
            waddr[k] = wp + n_wr[AW-1:0];
            n_wr     = n_wr + CW'(bus.WR_EN[k]);
        end
    end

    // Space check uses occupancy before the edge; a same-cycle dequeue does not help.
    always_comb begin
        free_cnt = CW'(DEPTH) - cnt;
        accept   = (n_wr <= free_cnt);
        deq      = (cnt != '0) && !bus.pipe_stall;
        cnt_next = cnt + (accept ? n_wr : '0) - CW'(deq);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rp    <= '0;
            wp    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (bus.flush) begin
            rp    <= '0;
            wp    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (deq) begin
                rp <= rp + AW'(1);
            end
            if (accept) begin
                wp <= wp + n_wr[AW-1:0];
            end else begin
                ovf_q <= 1'b1;
            end
            cnt <= cnt_next;
        end
    end

    // Storage is never cleared; a stray write during reset lands in an unoccupied slot.
    always_ff @(posedge CLK) begin
        if (!bus.flush && accept) begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.WR_EN[k]) begin
                    mem[waddr[k]] <= bus.IN_uop[k*UOP_W +: UOP_W];
                end
            end
        end
    end

    always_comb begin
        bus.OUT_valid = (cnt != '0);
        bus.OUT_uop   = bus.OUT_valid ? mem[rp] : '0;
        bus.Q_full    = (free_cnt < CW'(NWR));
        bus.count     = cnt;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_uop_fifo_nw.sv
// Bench for uop_fifo_nw: queue-based reference model, a negedge monitor that
// checks each dequeued micro-op, directed scenarios and a random phase.
module tb_uop_fifo_nw;
    localparam int UOP_W = 39;
    localparam int DEPTH = 16;
    localparam int NWR   = 4;

    logic clk;
    logic rst;

    uop_fifo_nw_if #(.UOP_W(UOP_W), .DEPTH(DEPTH), .NWR(NWR)) bus ();

    uop_fifo_nw #(.UOP_W(UOP_W), .DEPTH(DEPTH), .NWR(NWR)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [UOP_W-1:0] exp_q [$];
    int mdl_cnt = 0;
    bit mdl_ovf = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [UOP_W-1:0] rnd_uop();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[UOP_W-1:0];
    endfunction

    function automatic logic [NWR*UOP_W-1:0] rnd_data();
        logic [NWR*UOP_W-1:0] d;
        for (int k = 0; k < NWR; k++) d[k*UOP_W +: UOP_W] = rnd_uop();
        return d;
    endfunction

    // Monitor: every cycle the consumer takes the head, it must be the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.OUT_valid && !bus.pipe_stall && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_valid", 64'(bus.OUT_valid), 64'(0));
                end else begin
                    logic [UOP_W-1:0] e;
                    e = exp_q.pop_front();
                    chk("mon_deq_uop", 64'(bus.OUT_uop), 64'(e));
                end
            end else if (!bus.OUT_valid) begin
                chk("mon_nop_uop", 64'(bus.OUT_uop), 64'(0));
            end
        end
    end

    // Issue one cycle of stimulus, update the reference model, wait past the edge.
    task automatic cycle(input logic [NWR-1:0] we, input logic [NWR*UOP_W-1:0] d,
                         input bit stall, input bit fl);
        int n;
        bit dq;
        bus.WR_EN      = we;
        bus.IN_uop     = d;
        bus.pipe_stall = stall;
        bus.flush      = fl;
        n  = $countones(we);
        dq = (mdl_cnt != 0) && !stall;
        if (fl) begin
            exp_q.delete();
            mdl_cnt = 0;
            mdl_ovf = 1'b0;
        end else begin
            if (n <= DEPTH - mdl_cnt) begin
                for (int k = 0; k < NWR; k++)
                    if (we[k]) exp_q.push_back(d[k*UOP_W +: UOP_W]);
                mdl_cnt += n;
            end else begin
                mdl_ovf = 1'b1;
            end
            if (dq) mdl_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [UOP_W-1:0] head;
        head = (mdl_cnt != 0 && exp_q.size() != 0) ? exp_q[0] : '0;
        chk({tag, ".count"}, 64'(bus.count), 64'(mdl_cnt));
        chk({tag, ".valid"}, 64'(bus.OUT_valid), 64'(mdl_cnt != 0));
        chk({tag, ".qfull"}, 64'(bus.Q_full), 64'((DEPTH - mdl_cnt) < NWR));
        chk({tag, ".ovf"}, 64'(bus.ovf), 64'(mdl_ovf));
        chk({tag, ".head"}, 64'(bus.OUT_uop), 64'(head));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && mdl_cnt > 0; i++) begin
            cycle('0, '0, 1'b0, 1'b0);
            check_state(tag);
        end
        chk({tag, ".empty"}, 64'(bus.count), 64'(0));
        chk({tag, ".sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [UOP_W-1:0] a_uop;
        logic [UOP_W-1:0] b_uop;
        logic [NWR*UOP_W-1:0] d;
        logic [NWR-1:0] we;
        int sent;
        int ngrp;
        int idx;
        int t;

        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.IN_uop     = '0;
        bus.WR_EN      = '0;
        bus.pipe_stall = 1'b1;
        #12;
        chk("rst.valid", 64'(bus.OUT_valid), 64'(0));
        chk("rst.uop", 64'(bus.OUT_uop), 64'(0));
        chk("rst.qfull", 64'(bus.Q_full), 64'(0));
        chk("rst.count", 64'(bus.count), 64'(0));
        chk("rst.ovf", 64'(bus.ovf), 64'(0));
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Gapped enable 1010 packs ports 1 and 3 into consecutive slots.
        a_uop = 39'h12_3456_789A;
        b_uop = 39'h7E_DCBA_9876;
        d = rnd_data();
        d[1*UOP_W +: UOP_W] = a_uop;
        d[3*UOP_W +: UOP_W] = b_uop;
        cycle(4'b1010, d, 1'b1, 1'b0);
        check_state("cmp0");
        chk("cmp.count2", 64'(bus.count), 64'(2));
        chk("cmp.headA", 64'(bus.OUT_uop), 64'(a_uop));
        cycle('0, '0, 1'b0, 1'b0);
        check_state("cmp1");
        chk("cmp.headB", 64'(bus.OUT_uop), 64'(b_uop));
        cycle('0, '0, 1'b0, 1'b0);
        check_state("cmp2");
        chk("cmp.valid0", 64'(bus.OUT_valid), 64'(0));
        chk("cmp.nop", 64'(bus.OUT_uop), 64'(0));

        // Full threshold: 12 leaves exactly NWR free, 13 does not.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, rnd_data(), 1'b1, 1'b0);
            check_state("thr");
        end
        chk("thr.count12", 64'(bus.count), 64'(12));
        chk("thr.qfull12", 64'(bus.Q_full), 64'(0));
        cycle(4'b0001, rnd_data(), 1'b1, 1'b0);
        chk("thr.count13", 64'(bus.count), 64'(13));
        chk("thr.qfull13", 64'(bus.Q_full), 64'(1));

        // Overflow: 3 into 2 free slots is dropped whole though a dequeue happens.
        cycle(4'b0100, rnd_data(), 1'b1, 1'b0);
        chk("ovf.count14", 64'(bus.count), 64'(14));
        cycle(4'b0111, rnd_data(), 1'b0, 1'b0);
        check_state("ovf0");
        chk("ovf.count13", 64'(bus.count), 64'(13));
        chk("ovf.set", 64'(bus.ovf), 64'(1));
        cycle(4'b1000, rnd_data(), 1'b1, 1'b0);
        check_state("ovf1");
        chk("ovf.count14b", 64'(bus.count), 64'(14));
        chk("ovf.sticky", 64'(bus.ovf), 64'(1));
        cycle(4'b0011, rnd_data(), 1'b1, 1'b0);
        check_state("full");
        chk("full.count16", 64'(bus.count), 64'(16));
        cycle(4'b0001, rnd_data(), 1'b0, 1'b0);
        check_state("fulldeq");
        chk("fulldeq.count15", 64'(bus.count), 64'(15));

        // Flush beats a same-cycle write group and dequeue.
        for (int i = 0; i < 6; i++) begin
            cycle('0, '0, 1'b0, 1'b0);
            check_state("pre_flush");
        end
        chk("flush.count9", 64'(bus.count), 64'(9));
        cycle(4'b1111, rnd_data(), 1'b0, 1'b1);
        check_state("flush");
        chk("flush.count0", 64'(bus.count), 64'(0));
        chk("flush.valid0", 64'(bus.OUT_valid), 64'(0));
        chk("flush.ovf0", 64'(bus.ovf), 64'(0));

        // Wrap-around stream of 40 tagged micro-ops, 3 per group, random stalls.
        sent = 0;
        for (int g = 0; g < 400 && sent < 40; g++) begin
            we = '0;
            d  = rnd_data();
            if (DEPTH - mdl_cnt >= 3) begin
                ngrp = (40 - sent >= 3) ? 3 : 40 - sent;
                we   = '1;
                idx  = $urandom_range(0, NWR - 1);
                for (int r = 0; r < NWR - ngrp; r++) we[(idx + r) % NWR] = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if (we[k]) begin
                        d[k*UOP_W +: UOP_W] = {8'hA5, 31'(sent)};
                        sent++;
                    end
                end
            end
            cycle(we, d, 1'($urandom_range(0, 1)), 1'b0);
            check_state("stream");
        end
        chk("stream.sent", 64'(sent), 64'(40));
        drain("stream_drain");
        chk("stream.no_ovf", 64'(bus.ovf), 64'(0));

        // Asynchronous reset mid-cycle with five entries queued.
        cycle(4'b1111, rnd_data(), 1'b1, 1'b0);
        cycle(4'b0010, rnd_data(), 1'b1, 1'b0);
        chk("arst.count5", 64'(bus.count), 64'(5));
        #1 rst = 1'b1;
        #1;
        chk("arst.valid0", 64'(bus.OUT_valid), 64'(0));
        chk("arst.count0", 64'(bus.count), 64'(0));
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        #1 rst = 1'b0;
        cycle(4'b0110, rnd_data(), 1'b1, 1'b0);
        check_state("post_rst");
        chk("post_rst.count2", 64'(bus.count), 64'(2));
        drain("post_rst_drain");

        // Random traffic including overflow and occasional flush.
        for (int i = 0; i < 300; i++) begin
            t = $urandom_range(0, 3);
            cycle(NWR'($urandom()), rnd_data(), t != 0, $urandom_range(0, 40) == 0);
            check_state("rand");
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
